// File: rtl/ex2_stage.sv
// EX2 stage: increments write back after 1 cycle; loads/stores hold a single memory request until mem_ack.
// out_stall holds upstream while a memory op is pending. Optional macro EX2_INC_SATURATE_EN makes increment saturate.
module ex2_stage #(
  parameter int IMMEDIATE_WIDTH   = 16,
  parameter int DATA_WIDTH        = 64,
  parameter int REG_INDEX_BITS    = 5,
  parameter int THREAD_INDEX_BITS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_increment_flag,
  input  logic                         in_load_word_flag,
  input  logic                         in_store_word_flag,
  input  logic [IMMEDIATE_WIDTH-1:0]   in_immediate,
  input  logic [THREAD_INDEX_BITS-1:0] in_thread_index,
  input  logic [REG_INDEX_BITS-1:0]    in_reg_index,
  input  logic [DATA_WIDTH-1:0]        in_reg_data,
  output logic                         out_stall,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [IMMEDIATE_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic                         mem_ack,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic                         out_wb_valid,
  output logic [THREAD_INDEX_BITS-1:0] out_wb_thread_index,
  output logic [REG_INDEX_BITS-1:0]    out_wb_reg_index,
  output logic [DATA_WIDTH-1:0]        out_wb_data
);

  typedef enum logic {S_IDLE = 1'b0, S_MEM = 1'b1} state_t;

  localparam logic [DATA_WIDTH-1:0] LP_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                         r_state;
  state_t                         w_next_state;
  logic                           r_we;
  logic [IMMEDIATE_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]          r_wdata;
  logic [REG_INDEX_BITS-1:0]      r_reg_index;
  logic [THREAD_INDEX_BITS-1:0]   r_thread_index;
  logic                           r_wb_valid;
  logic [DATA_WIDTH-1:0]          r_wb_data;
  logic [REG_INDEX_BITS-1:0]      r_wb_reg;
  logic [THREAD_INDEX_BITS-1:0]   r_wb_thread;

  logic                           w_capture;
  logic                           w_capture_store;
  logic                           w_wb_valid;
  logic [DATA_WIDTH-1:0]          w_wb_data;
  logic [REG_INDEX_BITS-1:0]      w_wb_reg;
  logic [THREAD_INDEX_BITS-1:0]   w_wb_thread;
  logic [DATA_WIDTH-1:0]          w_inc_data;

`ifdef EX2_INC_SATURATE_EN
  assign w_inc_data = (&in_reg_data) ? in_reg_data : in_reg_data + LP_ONE;
`else
  assign w_inc_data = in_reg_data + LP_ONE;
`endif

  // Decode priority in IDLE is load > store > increment; inputs are ignored in MEM.
  always_comb begin
    w_next_state    = r_state;
    w_capture       = 1'b0;
    w_capture_store = 1'b0;
    w_wb_valid      = 1'b0;
    w_wb_data       = r_wb_data;
    w_wb_reg        = r_wb_reg;
    w_wb_thread     = r_wb_thread;
    case (r_state)
      S_IDLE: begin
        if (in_load_word_flag) begin
          w_capture    = 1'b1;
          w_next_state = S_MEM;
        end else if (in_store_word_flag) begin
          w_capture       = 1'b1;
          w_capture_store = 1'b1;
          w_next_state    = S_MEM;
        end else if (in_increment_flag) begin
          w_wb_valid  = 1'b1;
          w_wb_data   = w_inc_data;
          w_wb_reg    = in_reg_index;
          w_wb_thread = in_thread_index;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          w_next_state = S_IDLE;
          if (!r_we) begin
            w_wb_valid  = 1'b1;
            w_wb_data   = mem_rdata;
            w_wb_reg    = r_reg_index;
            w_wb_thread = r_thread_index;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_reg_index    <= '0;
      r_thread_index <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_data      <= '0;
      r_wb_reg       <= '0;
      r_wb_thread    <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wb_valid <= w_wb_valid;
      if (w_wb_valid) begin
        r_wb_data   <= w_wb_data;
        r_wb_reg    <= w_wb_reg;
        r_wb_thread <= w_wb_thread;
      end
      if (w_capture) begin
        r_we           <= w_capture_store;
        r_addr         <= in_immediate;
        r_wdata        <= in_reg_data;
        r_reg_index    <= in_reg_index;
        r_thread_index <= in_thread_index;
      end
    end
  end

  assign mem_req             = (r_state == S_MEM);
  assign out_stall           = (r_state == S_MEM);
  assign mem_we              = r_we;
  assign mem_addr            = r_addr;
  assign mem_wdata           = r_wdata;
  assign out_wb_valid        = r_wb_valid;
  assign out_wb_data         = r_wb_data;
  assign out_wb_reg_index    = r_wb_reg;
  assign out_wb_thread_index = r_wb_thread;

endmodule
